// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl
//   Sequencer for the even-parity serial datapath. Takes a parallel word over
//   valid/ready, shifts it out one bit per clock, appends the even-parity bit
//   (XOR of all data bits), then holds off for GAP idle cycles before accepting
//   the next word. Frame markers let a downstream checker align cycle-exact.
//
// Parameters
//   DW         data bits per frame (>= 1)
//   LSB_FIRST  1: bit 0 goes out first; 0: bit DW-1 goes out first
//   GAP        idle cycles after the parity bit before in_ready returns (>= 0)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   in_valid     in   parallel word offered
//   in_data      in   word to frame [DW-1:0]
//   in_ready     out  word can be accepted this cycle (IDLE only)
//   ser_out      out  serial bit: data bits, then parity bit
//   ser_valid    out  ser_out carries a frame bit
//   frame_start  out  high with the first data bit
//   frame_end    out  high with the parity bit
//   par_bit      out  parity of the last completed frame, held until the next ends
//   busy         out  high whenever not idle
//
// All outputs are flops loaded from the next-state logic, so the bit shown in a
// cycle is chosen at the edge that starts that cycle.

module parity_frame_ctrl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned GAP       = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          frame_start,
    output logic          frame_end,
    output logic          par_bit,
    output logic          busy
);

    localparam int unsigned CW      = $clog2(DW + 1);
    // Always at least one bit wide, even when GAP is 0 and the counter is unused.
    localparam int unsigned GW      = $clog2(GAP + 2);
    localparam int unsigned GapLast = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic [GW-1:0] gap_q, gap_d;

    logic ser_out_d, ser_valid_d, frame_start_d, frame_end_d;
    logic par_bit_d, in_ready_d, busy_d;

    // The first bit is taken straight from in_data on the accepting edge, later
    // bits from the shift register; both paths share the same pick/shift logic.
    logic [DW-1:0] src;
    logic [DW-1:0] rest;
    logic          head;

    always_comb begin
        src  = (state_q == StIdle) ? in_data : shift_q;
        head = (LSB_FIRST != 0) ? src[0] : src[DW-1];
        rest = (LSB_FIRST != 0) ? (src >> 1) : (src << 1);
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        gap_d         = gap_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        par_bit_d     = par_bit;

        case (state_q)
            StIdle: begin
                // in_ready is always high here, so in_valid alone is the handshake.
                if (in_valid) begin
                    shift_d       = rest;
                    cnt_d         = CW'(1);
                    acc_d         = head;
                    ser_out_d     = head;
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    state_d       = StShift;
                end
            end
            StShift: begin
                // cnt_q counts bits already on the wire; after the DW-th, emit parity.
                if (cnt_q == CW'(DW)) begin
                    ser_out_d   = acc_q;
                    ser_valid_d = 1'b1;
                    frame_end_d = 1'b1;
                    par_bit_d   = acc_q;
                    state_d     = StParity;
                end else begin
                    shift_d     = rest;
                    cnt_d       = cnt_q + 1'b1;
                    acc_d       = acc_q ^ head;
                    ser_out_d   = head;
                    ser_valid_d = 1'b1;
                end
            end
            StParity: begin
                acc_d   = 1'b0;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = (GAP == 0) ? StIdle : StGap;
            end
            StGap: begin
                if (gap_q == GW'(GapLast)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            gap_q       <= '0;
            in_ready    <= 1'b1;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            par_bit     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            in_ready    <= in_ready_d;
            ser_out     <= ser_out_d;
            ser_valid   <= ser_valid_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            par_bit     <= par_bit_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl. Four instances cover the parameter corners:
//   0: DW=8  LSB_FIRST=1 GAP=1
//   1: DW=16 LSB_FIRST=1 GAP=2
//   2: DW=8  LSB_FIRST=0 GAP=0
//   3: DW=1  LSB_FIRST=1 GAP=0
// A frame-level model expands each accepted word into the per-cycle output
// sequence it must produce; every negedge all outputs are compared with it.
// Directed stimulus adds literal checks on the captured serial streams.

module tb_parity_frame_ctrl;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n = '0;
    logic [NI-1:0] vld   = '0;
    logic [15:0]   din [NI];

    wire [NI-1:0] rdy, so, sv, fs, fe, pb, bsy;

    int tests = 0;
    int fails = 0;

    parity_frame_ctrl #(.DW(8), .LSB_FIRST(1), .GAP(1)) u_a (
        .clk(clk), .rst(rst_n[0]), .in_valid(vld[0]), .in_data(din[0][7:0]),
        .in_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]),
        .frame_end(fe[0]), .par_bit(pb[0]), .busy(bsy[0])
    );
    parity_frame_ctrl #(.DW(16), .LSB_FIRST(1), .GAP(2)) u_b (
        .clk(clk), .rst(rst_n[1]), .in_valid(vld[1]), .in_data(din[1][15:0]),
        .in_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]),
        .frame_end(fe[1]), .par_bit(pb[1]), .busy(bsy[1])
    );
    parity_frame_ctrl #(.DW(8), .LSB_FIRST(0), .GAP(0)) u_c (
        .clk(clk), .rst(rst_n[2]), .in_valid(vld[2]), .in_data(din[2][7:0]),
        .in_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]),
        .frame_end(fe[2]), .par_bit(pb[2]), .busy(bsy[2])
    );
    parity_frame_ctrl #(.DW(1), .LSB_FIRST(1), .GAP(0)) u_d (
        .clk(clk), .rst(rst_n[3]), .in_valid(vld[3]), .in_data(din[3][0:0]),
        .in_ready(rdy[3]), .ser_out(so[3]), .ser_valid(sv[3]), .frame_start(fs[3]),
        .frame_end(fe[3]), .par_bit(pb[3]), .busy(bsy[3])
    );

    function automatic int p_dw(input int i);
        case (i)
            0: return 8;
            1: return 16;
            2: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic bit p_lsb(input int i);
        return (i != 2);
    endfunction

    function automatic int p_gap(input int i);
        case (i)
            0: return 1;
            1: return 2;
            default: return 0;
        endcase
    endfunction

    // Expected outputs for one cycle (par_bit tracked separately).
    typedef struct packed {
        logic so;
        logic sv;
        logic fs;
        logic fe;
        logic rdy;
        logic bsy;
    } exp_t;

    localparam exp_t IdleE = exp_t'(6'b000010);

    exp_t        cur [NI];
    exp_t        mq  [NI][$];
    logic        mpar [NI];
    logic [31:0] cap [NI];
    int          fs_last [NI];
    int          fs_prev [NI];
    int          cyc = 0;

    // Expand one accepted word into its full cycle sequence.
    task automatic push_frame(input int i, input logic [15:0] d);
        int   dw;
        int   ones;
        exp_t e;
        dw   = p_dw(i);
        ones = 0;
        for (int k = 0; k < dw; k++) begin
            e     = '0;
            e.bsy = 1'b1;
            e.sv  = 1'b1;
            e.fs  = (k == 0);
            e.so  = p_lsb(i) ? d[k] : d[dw-1-k];
            ones  = ones + int'(d[k]);
            mq[i].push_back(e);
        end
        e     = '0;
        e.bsy = 1'b1;
        e.sv  = 1'b1;
        e.fe  = 1'b1;
        e.so  = ((ones % 2) == 1);
        mq[i].push_back(e);
        for (int g = 0; g < p_gap(i); g++) begin
            e     = '0;
            e.bsy = 1'b1;
            mq[i].push_back(e);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                mq[i].delete();
                cur[i]  = IdleE;
                mpar[i] = 1'b0;
            end else begin
                if (cur[i].rdy && vld[i]) push_frame(i, din[i]);
                if (mq[i].size() > 0) begin
                    cur[i] = mq[i].pop_front();
                    if (cur[i].fe) mpar[i] = cur[i].so;
                end else begin
                    cur[i] = IdleE;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            exp_t       e;
            logic       ep;
            logic [6:0] got;
            logic [6:0] want;
            if (!rst_n[i]) begin
                e  = IdleE;
                ep = 1'b0;
            end else begin
                e  = cur[i];
                ep = mpar[i];
            end
            got  = {so[i], sv[i], fs[i], fe[i], rdy[i], bsy[i], pb[i]};
            want = {e, ep};
            tests = tests + 1;
            if (got !== want) begin
                fails = fails + 1;
                $display("FAIL cycle %0d dut%0d outputs (so sv fs fe rdy busy par): got %b want %b",
                         cyc, i, got, want);
            end
            if (rst_n[i] && sv[i]) begin
                if (fs[i]) begin
                    cap[i]     = '0;
                    fs_prev[i] = fs_last[i];
                    fs_last[i] = cyc;
                end
                cap[i] = {cap[i][30:0], so[i]};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests = tests + 1;
        if (got !== want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a word and wait for the handshake; returns in the first-bit cycle.
    task automatic send(input int i, input logic [15:0] d, input bit hold);
        bit ok;
        ok     = 1'b0;
        din[i] = d;
        vld[i] = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (rdy[i]) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        tick();
        if (!hold) vld[i] = 1'b0;
        chk($sformatf("accept dut%0d", i), 32'(ok), 32'd1);
    endtask

    task automatic wait_fe(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            tick();
            if (fe[i]) ok = 1'b1;
        end
        chk($sformatf("frame_end seen dut%0d", i), 32'(ok), 32'd1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < NI; i++) begin
            din[i]     = '0;
            cap[i]     = '0;
            fs_last[i] = 0;
            fs_prev[i] = 0;
        end
        repeat (3) tick();
        chk("reset in_ready", 32'(rdy), 32'hF);
        chk("reset busy", 32'(bsy), 32'h0);
        chk("reset ser_valid", 32'(sv), 32'h0);
        rst_n = '1;
        tick();

        // A5 LSB-first
        send(0, 16'h00A5, 1'b0);
        wait_fe(0);
        chk("A5 stream", 32'(cap[0][8:0]), 32'(9'b101001010));
        chk("A5 par_bit", 32'(pb[0]), 32'd0);

        // back-to-back with in_valid held; FF offered while busy must be ignored
        send(0, 16'h0001, 1'b1);
        din[0] = 16'h00FF;
        wait_fe(0);
        chk("01 stream", 32'(cap[0][8:0]), 32'(9'b100000001));
        chk("01 par_bit", 32'(pb[0]), 32'd1);
        tick();
        din[0] = 16'h0003;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (fs[0]) seen = 1'b1;
        end
        vld[0] = 1'b0;
        chk("second frame_start seen", 32'(seen), 32'd1);
        chk("b2b frame spacing", 32'(fs_last[0] - fs_prev[0]), 32'd11);
        wait_fe(0);
        chk("03 stream", 32'(cap[0][8:0]), 32'(9'b110000000));
        chk("03 par_bit", 32'(pb[0]), 32'd0);

        // 07, parity held afterwards
        send(0, 16'h0007, 1'b0);
        wait_fe(0);
        chk("07 stream", 32'(cap[0][8:0]), 32'(9'b111000001));
        repeat (3) begin
            tick();
            chk("07 par_bit held", 32'(pb[0]), 32'd1);
        end

        // reset at the 4th data bit of FF
        send(0, 16'h00FF, 1'b0);
        repeat (3) tick();
        chk("FF bit4 live", 32'(sv[0] & so[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("rst ser_out", 32'(so[0]), 32'd0);
        chk("rst ser_valid", 32'(sv[0]), 32'd0);
        chk("rst busy", 32'(bsy[0]), 32'd0);
        chk("rst in_ready", 32'(rdy[0]), 32'd1);
        chk("rst par_bit", 32'(pb[0]), 32'd0);
        repeat (2) tick();
        rst_n[0] = 1'b1;
        send(0, 16'h0080, 1'b0);
        wait_fe(0);
        chk("80 stream", 32'(cap[0][8:0]), 32'(9'b000000011));
        chk("80 par_bit", 32'(pb[0]), 32'd1);

        // DW=16
        send(1, 16'b0101110010101111, 1'b0);
        wait_fe(1);
        chk("w16 stream", 32'(cap[1][16:0]), 32'(17'b11110101001110100));
        chk("w16 frame even", 32'(^cap[1][16:0]), 32'd0);
        chk("w16 par_bit", 32'(pb[1]), 32'd0);

        // MSB-first, no gap
        send(2, 16'h00C1, 1'b0);
        wait_fe(2);
        chk("C1 stream", 32'(cap[2][8:0]), 32'(9'b110000011));
        chk("C1 par_bit", 32'(pb[2]), 32'd1);
        tick();
        chk("C1 in_ready after frame_end", 32'(rdy[2]), 32'd1);

        // DW=1
        send(3, 16'h0001, 1'b0);
        wait_fe(3);
        chk("dw1 one stream", 32'(cap[3][1:0]), 32'(2'b11));
        send(3, 16'h0000, 1'b0);
        wait_fe(3);
        chk("dw1 zero stream", 32'(cap[3][1:0]), 32'(2'b00));
        chk("dw1 par_bit", 32'(pb[3]), 32'd0);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
